// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the UART transmitter: first-word fall-through, valid/ready pop, sticky overflow.
// Optional registered almost_full output when UART_TX_FIFO_ALMOST_FULL_EN is defined.
module uart_tx_fifo #(
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned AF_LEVEL = 12
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [7:0]               wr_data_i,
    input  logic                     wr_en_i,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic [7:0]               tx_data_o,
    output logic                     tx_valid_o,
    input  logic                     tx_ready_i,
    output logic                     overflow_o,
`ifdef UART_TX_FIFO_ALMOST_FULL_EN
    output logic                     almost_full_o,
`endif
    input  logic                     overflow_clr_i
);

    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W  = ADDR_W + 1;

    logic [7:0]        mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              full_q, full_d;
    logic              valid_q, valid_d;
    logic              overflow_q, overflow_d;
    logic              push, pop;

    always_comb begin
        pop        = valid_q & tx_ready_i;
        // A pop frees a slot in the same cycle, so a full FIFO can still accept.
        push       = wr_en_i & (~full_q | pop);
        wr_ptr_d   = push ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + ADDR_W'(1) : rd_ptr_q;
        count_d    = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        full_d     = (count_d == CNT_W'(DEPTH));
        valid_d    = (count_d != '0);
        overflow_d = overflow_q;
        if (wr_en_i && !push) begin
            overflow_d = 1'b1;
        end else if (overflow_clr_i) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            valid_q    <= valid_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is intentionally not reset.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    assign full_o     = full_q;
    assign count_o    = count_q;
    assign tx_valid_o = valid_q;
    assign tx_data_o  = valid_q ? mem_q[rd_ptr_q] : 8'h00;
    assign overflow_o = overflow_q;

`ifdef UART_TX_FIFO_ALMOST_FULL_EN
    logic af_q, af_d;

    assign af_d = (count_d >= CNT_W'(AF_LEVEL));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            af_q <= 1'b0;
        end else begin
            af_q <= af_d;
        end
    end

    assign almost_full_o = af_q;
`else
    logic unused_af_level;
    assign unused_af_level = ^AF_LEVEL;
`endif

endmodule
